// File: rtl/crc22_trailer_framer.sv
// Readout framer: passes a contiguous 16-bit word stream and appends
// two CRC-22 (x^22+x+1) trailer words carrying markers and the CRC.
module crc22a (
  input  logic        clock,
  input  logic        reset,
  input  logic        init_i,
  input  logic [15:0] din_i,
  output logic [21:0] crc_o
);

  logic [21:0] crc_q, crc_d;

  // Sixteen serial steps, D[15] first; init_i restarts from a zero seed.
  function automatic logic [21:0] step16(
    input logic [21:0] c,
    input logic [15:0] d
  );
    logic        fb;
    logic [21:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[21] ^ d[i];
      r  = {r[20:0], fb} ^ {20'b0, fb, 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = step16(init_i ? 22'b0 : crc_q, din_i);
  end

  always_ff @(posedge clock) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

module crc22_trailer_framer #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [4:0]  MARKER0   = 5'h1A,
  parameter logic [4:0]  MARKER1   = 5'h1B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] din_i,
  input  logic        din_valid_i,
  input  logic        din_first_i,
  input  logic        din_last_i,
  output logic        din_ready_o,
  output logic [15:0] dout_o,
  output logic        dout_valid_o,
  output logic        dout_crc_o,
  output logic        dout_last_o,
  output logic [10:0] frame_wc_o,
  output logic        frame_err_o
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, DATA, CRC0, CRC1} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   hold_q;
  logic [15:0]   dout_q;
  logic          valid_q, crc_q, last_q, err_q;
  logic [10:0]   wc_q;
  logic [21:0]   crc;
  logic          accept, crc_rst, at_max;
  logic [11:0]   wc_sum;

  assign din_ready_o = (state_q == IDLE) || (state_q == DATA);
  assign accept      = din_valid_i && din_ready_o &&
                       (din_first_i || state_q == DATA);
  assign crc_rst     = reset || !accept;
  assign cnt_d       = din_first_i ? CW'(1) : cnt_q + 1'b1;
  assign at_max      = (cnt_d == CW'(MAX_WORDS));
  assign wc_sum      = 12'(cnt_q) + 12'd2;

  // No enable on the CRC: it is zeroed on every cycle nothing is accepted.
  crc22a u_crc (
    .clock  (clock),
    .reset  (crc_rst),
    .init_i (din_first_i),
    .din_i  (din_i),
    .crc_o  (crc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      crc_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      crc_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        dout_q  <= din_i;
        valid_q <= 1'b1;
        cnt_q   <= cnt_d;
      end
      unique case (state_q)
        IDLE, DATA: begin
          if (accept) begin
            if (state_q == DATA && din_first_i) err_q <= 1'b1;
            if (din_last_i) begin
              state_q <= CRC0;
            end else if (at_max) begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end else if (state_q == DATA) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        CRC0: begin
          hold_q  <= crc[21:11];
          dout_q  <= {MARKER0, crc[10:0]};
          valid_q <= 1'b1;
          crc_q   <= 1'b1;
          state_q <= CRC1;
        end
        CRC1: begin
          dout_q  <= {MARKER1, hold_q};
          valid_q <= 1'b1;
          crc_q   <= 1'b1;
          last_q  <= 1'b1;
          wc_q    <= wc_sum[11] ? 11'h7FF : wc_sum[10:0];
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign dout_crc_o   = crc_q;
  assign dout_last_o  = last_q;
  assign frame_wc_o   = wc_q;
  assign frame_err_o  = err_q;

endmodule
